// File: rtl/aes_pkg.sv
// Shared AES types and the byte-ordering helpers for a 128-bit state (byte0 = MSB).
package aes_pkg;

    localparam int AES_NBYTES  = 16;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_STATE_W = AES_NBYTES * AES_BYTE_W;
    localparam int AES_CNT_W   = $clog2(AES_NBYTES) + 1;

    typedef logic [AES_BYTE_W-1:0]  byte_t;
    typedef logic [AES_STATE_W-1:0] state_t;
    typedef logic [AES_CNT_W-1:0]   cnt_t;

    typedef enum logic [1:0] {
        SB_IDLE,
        SB_LOOKUP,
        SB_DONE
    } sb_state_e;

    // Byte k lives at bits [127-8k -: 8]; these two functions are the only place that knows it.
    function automatic byte_t get_byte(state_t s, cnt_t idx);
        return s[(AES_NBYTES - 1 - int'(idx)) * AES_BYTE_W +: AES_BYTE_W];
    endfunction

    function automatic state_t set_byte(state_t s, cnt_t idx, byte_t b);
        state_t r;
        r = s;
        r[(AES_NBYTES - 1 - int'(idx)) * AES_BYTE_W +: AES_BYTE_W] = b;
        return r;
    endfunction

endpackage

// File: rtl/mod_valid_delay.sv
// Aligns the ROM issue-valid with returning ROM data; DEPTH=0 collapses to a wire.
module mod_valid_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_pipe
            logic [DEPTH-1:0] stage_reg;
            logic [DEPTH:0]   chain;

            assign chain = {stage_reg, din};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= chain[DEPTH-1:0];
                end
            end

            assign dout = stage_reg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/mod_subbytes_ctrl.sv
// SubBytes sequencer: walks one latched state through the shared S-box ROM a byte per
// cycle and presents the substituted state on a valid/ready output.
module mod_subbytes_ctrl
    import aes_pkg::*;
#(
    parameter int NBYTES      = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int ROM_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NBYTES*DATA_WIDTH-1:0] in_state,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NBYTES*DATA_WIDTH-1:0] out_state,
    output logic                         rom_en,
    output logic [DATA_WIDTH-1:0]        rom_addr,
    input  logic [DATA_WIDTH-1:0]        rom_data,
    output logic                         busy
);

    localparam int CNT_W = $clog2(NBYTES) + 1;
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(NBYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

    sb_state_e state_reg, state_next;

    logic [NBYTES*DATA_WIDTH-1:0] hold_reg;
    logic [NBYTES*DATA_WIDTH-1:0] result_reg;
    logic [CNT_W-1:0]             issue_cnt_reg;
    logic [CNT_W-1:0]             cap_cnt_reg;

    logic accept;
    logic issue;
    logic cap_valid;
    logic cap_last;

    assign accept   = in_valid && (state_reg == SB_IDLE);
    assign issue    = (state_reg == SB_LOOKUP) && (issue_cnt_reg < CNT_END);
    assign cap_last = cap_valid && (cap_cnt_reg == CNT_LAST);

    // Reset clears the delay line, so a read in flight at reset never lands in result_reg.
    mod_valid_delay #(
        .DEPTH (ROM_LATENCY)
    ) u_valid_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (issue),
        .dout  (cap_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= SB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SB_IDLE:   if (accept)    state_next = SB_LOOKUP;
            SB_LOOKUP: if (cap_last)  state_next = SB_DONE;
            SB_DONE:   if (out_ready) state_next = SB_IDLE;
            default:                  state_next = SB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg      <= '0;
            result_reg    <= '0;
            issue_cnt_reg <= '0;
            cap_cnt_reg   <= '0;
        end else begin
            if (accept) begin
                hold_reg      <= in_state;
                issue_cnt_reg <= '0;
                cap_cnt_reg   <= '0;
            end
            if (issue) begin
                issue_cnt_reg <= issue_cnt_reg + 1'b1;
            end
            if (cap_valid) begin
                result_reg  <= set_byte(result_reg, cap_cnt_reg, rom_data);
                cap_cnt_reg <= cap_cnt_reg + 1'b1;
            end
        end
    end

    // rom_en/rom_addr are decoded from state so that reset drops them without waiting for a clock.
    assign rom_en    = issue;
    assign rom_addr  = issue ? get_byte(hold_reg, issue_cnt_reg) : '0;
    assign in_ready  = (state_reg == SB_IDLE);
    assign out_valid = (state_reg == SB_DONE);
    assign busy      = (state_reg != SB_IDLE);
    assign out_state = result_reg;

endmodule

// File: tb/tb_mod_subbytes_ctrl.sv
// Self-checking bench: three DUTs (ROM_LATENCY 0/1/2) each with a behavioural S-box ROM.
module tb_mod_subbytes_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] in_state;
    logic         out_ready;
    logic         in_valid_a  [3];
    logic         in_ready_a  [3];
    logic         out_valid_a [3];
    logic [127:0] out_state_a [3];
    logic         rom_en_a    [3];
    logic [7:0]   rom_addr_a  [3];
    logic [7:0]   rom_data_a  [3];
    logic         busy_a      [3];

    logic [7:0] sbox_t [256];

    int checks = 0;
    int failures = 0;
    int acc_cyc [3];
    logic [127:0] q0 [$];
    logic [127:0] q1 [$];
    logic [127:0] q2 [$];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            mod_subbytes_ctrl #(
                .NBYTES      (16),
                .DATA_WIDTH  (8),
                .ROM_LATENCY (gi)
            ) dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid_a[gi]),
                .in_ready  (in_ready_a[gi]),
                .in_state  (in_state),
                .out_valid (out_valid_a[gi]),
                .out_ready (out_ready),
                .out_state (out_state_a[gi]),
                .rom_en    (rom_en_a[gi]),
                .rom_addr  (rom_addr_a[gi]),
                .rom_data  (rom_data_a[gi]),
                .busy      (busy_a[gi])
            );

            logic [7:0] p0_reg = 8'h00;
            logic [7:0] p1_reg = 8'h00;
            always @(posedge clk) begin
                if (rom_en_a[gi]) p0_reg <= sbox_t[rom_addr_a[gi]];
                p1_reg <= p0_reg;
            end
            if (gi == 0) begin : g_l0
                assign rom_data_a[gi] = sbox_t[rom_addr_a[gi]];
            end else if (gi == 1) begin : g_l1
                assign rom_data_a[gi] = p0_reg;
            end else begin : g_l2
                assign rom_data_a[gi] = p1_reg;
            end
        end
    endgenerate

    function automatic logic [7:0] gmul(logic [7:0] a_in, logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] affine(logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_state(logic [127:0] st);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sbox_t[st[127-8*k -: 8]];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(int idx, logic [127:0] v);
        case (idx)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic send(int idx, logic [127:0] st);
        in_state = st;
        in_valid_a[idx] = 1'b1;
        chk("in_ready_before_send", 128'(in_ready_a[idx]), 128'(1));
        tick();
        acc_cyc[idx] = cyc;
        in_valid_a[idx] = 1'b0;
        push_exp(idx, sub_state(st));
        $display("txn send dut%0d state=%h cyc=%0d", idx, st, cyc);
    endtask

    task automatic wait_out(int idx, int lat, string tag, output int en_cnt, output logic [7:0] addr_or);
        logic got;
        logic [127:0] exp;
        int qs;
        got = 1'b0;
        en_cnt = 0;
        addr_or = 8'h00;
        for (int i = 0; i < 100 && !got; i++) begin
            if (out_valid_a[idx]) begin
                got = 1'b1;
            end else begin
                if (rom_en_a[idx]) begin
                    en_cnt++;
                    addr_or = addr_or | rom_addr_a[idx];
                end
                tick();
            end
        end
        chk({tag, "_out_valid"}, 128'(got), 128'(1));
        chk({tag, "_latency"}, 128'(cyc - acc_cyc[idx]), 128'(lat));
        case (idx)
            0: qs = q0.size();
            1: qs = q1.size();
            default: qs = q2.size();
        endcase
        chk({tag, "_scoreboard_nonempty"}, 128'(qs > 0), 128'(1));
        if (qs > 0) begin
            case (idx)
                0: exp = q0.pop_front();
                1: exp = q1.pop_front();
                default: exp = q2.pop_front();
            endcase
            chk({tag, "_out_state"}, out_state_a[idx], exp);
        end
        $display("txn result dut%0d %s state=%h cyc=%0d", idx, tag, out_state_a[idx], cyc);
    endtask

    task automatic drain(int idx, string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_out_valid_after_handshake"}, 128'(out_valid_a[idx]), 128'(0));
    endtask

    initial begin
        logic [127:0] fips, va, vb, vc, vd, snap;
        int en;
        int bad;
        int acc_a;
        logic [7:0] ao;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = affine(inv);
        end

        fips = 128'h00112233445566778899aabbccddeeff;
        in_state = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) in_valid_a[i] = 1'b0;

        repeat (3) tick();
        chk("rst_out_valid", 128'(out_valid_a[1]), 128'(0));
        chk("rst_rom_en", 128'(rom_en_a[1]), 128'(0));
        chk("rst_busy", 128'(busy_a[1]), 128'(0));
        chk("rst_out_state", out_state_a[1], 128'(0));
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 128'(in_ready_a[1]), 128'(1));
        chk("rst_rom_addr", 128'(rom_addr_a[1]), 128'(0));

        // FIPS-197 vector, ROM_LATENCY=1
        send(1, fips);
        wait_out(1, 17, "fips_l1", en, ao);
        chk("fips_l1_out_state_const", out_state_a[1], 128'h638293c31bfc33f5c4eeacea4bc12816);
        chk("fips_l1_rom_en_cycles", 128'(en), 128'(16));
        drain(1, "fips_l1");

        // all-zero state
        send(1, 128'h0);
        wait_out(1, 17, "zero", en, ao);
        chk("zero_out_state_const", out_state_a[1], {16{8'h63}});
        chk("zero_rom_en_cycles", 128'(en), 128'(16));
        chk("zero_rom_addr_or", 128'(ao), 128'(0));

        // backpressure: result held in DONE, in_valid pulses ignored
        snap = out_state_a[1];
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid_a[1] = i[0];
            in_state = {$urandom, $urandom, $urandom, $urandom};
            tick();
            if (out_valid_a[1] !== 1'b1 || out_state_a[1] !== snap || in_ready_a[1] !== 1'b0) bad++;
        end
        in_valid_a[1] = 1'b0;
        chk("bp_stable_cycles_bad", 128'(bad), 128'(0));
        drain(1, "bp");
        chk("bp_no_accept_busy", 128'(busy_a[1]), 128'(0));
        chk("bp_no_accept_queue", 128'(q1.size()), 128'(0));

        // back-to-back with in_valid held high
        va = {$urandom, $urandom, $urandom, $urandom};
        vb = {$urandom, $urandom, $urandom, $urandom};
        in_state = va;
        in_valid_a[1] = 1'b1;
        out_ready = 1'b1;
        tick();
        acc_cyc[1] = cyc;
        acc_a = cyc;
        push_exp(1, sub_state(va));
        $display("txn send dut1 state=%h cyc=%0d", va, cyc);
        in_state = vb;
        wait_out(1, 17, "b2b_a", en, ao);
        tick();
        chk("b2b_handshake_out_valid", 128'(out_valid_a[1]), 128'(0));
        chk("b2b_in_ready_after_hs", 128'(in_ready_a[1]), 128'(1));
        tick();
        acc_cyc[1] = cyc;
        push_exp(1, sub_state(vb));
        $display("txn send dut1 state=%h cyc=%0d", vb, cyc);
        in_valid_a[1] = 1'b0;
        chk("b2b_second_accept_busy", 128'(busy_a[1]), 128'(1));
        chk("b2b_accept_spacing", 128'(cyc - acc_a), 128'(19));
        wait_out(1, 17, "b2b_b", en, ao);
        tick();
        out_ready = 1'b0;
        chk("b2b_b_out_valid_after_handshake", 128'(out_valid_a[1]), 128'(0));

        // reset in the middle of LOOKUP
        vc = {$urandom, $urandom, $urandom, $urandom};
        send(1, vc);
        repeat (7) tick();
        chk("mid_rst_rom_en_before", 128'(rom_en_a[1]), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rom_en", 128'(rom_en_a[1]), 128'(0));
        chk("mid_rst_rom_addr", 128'(rom_addr_a[1]), 128'(0));
        chk("mid_rst_busy", 128'(busy_a[1]), 128'(0));
        chk("mid_rst_out_valid", 128'(out_valid_a[1]), 128'(0));
        chk("mid_rst_out_state", out_state_a[1], 128'(0));
        q1.delete();
        $display("txn reset dut1 discarded state=%h cyc=%0d", vc, cyc);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        vd = {$urandom, $urandom, $urandom, $urandom};
        send(1, vd);
        wait_out(1, 17, "post_rst", en, ao);
        drain(1, "post_rst");

        // latency sweep
        send(0, fips);
        wait_out(0, 16, "fips_l0", en, ao);
        chk("fips_l0_rom_en_cycles", 128'(en), 128'(16));
        drain(0, "fips_l0");
        send(2, fips);
        wait_out(2, 18, "fips_l2", en, ao);
        chk("fips_l2_rom_en_cycles", 128'(en), 128'(16));
        drain(2, "fips_l2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
